// File: rtl/if_ctrl_pkg.sv
// Shared types and defaults for the fetch-stage sequencer: exception codes,
// FSM states and the exception-priority helper.
package if_ctrl_pkg;

  localparam int unsigned      PC_WIDTH_DEF    = 32;
  localparam int unsigned      INSTR_WIDTH_DEF = 32;
  localparam logic [31:0]      RESET_PC_DEF    = 32'h0000_0000;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_BUS_ERR  = 2'b10
  } exc_e;

  typedef enum logic {
    IFC_RUN  = 1'b0,
    IFC_HALT = 1'b1
  } ifc_state_e;

  // Misalign takes precedence when the bus raises both flags.
  function automatic exc_e exc_code(input logic misalign, input logic bus_err);
    if (misalign)     return EXC_MISALIGN;
    else if (bus_err) return EXC_BUS_ERR;
    else              return EXC_NONE;
  endfunction

endpackage

// File: rtl/if_ctrl_if.sv
// Instruction-fetch bus plus the fetch-to-decode valid/ready handshake.
// master = fetch stage (if_ctrl), slave = bus/decode side.
interface if_ctrl_if #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic [PC_WIDTH-1:0]    fetch_pc_o;
  logic [INSTR_WIDTH-1:0] fetch_instr_i;
  logic                   fetch_misalign_i;
  logic                   fetch_bus_err_i;
  logic                   id_valid_o;
  logic                   id_ready_i;
  logic [PC_WIDTH-1:0]    id_pc_o;
  logic [INSTR_WIDTH-1:0] id_instr_o;
  logic [1:0]             id_exc_o;

  modport master (
    output fetch_pc_o,
    input  fetch_instr_i, fetch_misalign_i, fetch_bus_err_i,
    output id_valid_o, id_pc_o, id_instr_o, id_exc_o,
    input  id_ready_i
  );

  modport slave (
    input  fetch_pc_o,
    output fetch_instr_i, fetch_misalign_i, fetch_bus_err_i,
    input  id_valid_o, id_pc_o, id_instr_o, id_exc_o,
    output id_ready_i
  );
endinterface

// File: rtl/if_out_reg.sv
// Single-entry valid/ready pipeline register with synchronous flush.
// Payload holds its last value whenever no new entry is loaded.
module if_out_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_ctrl.sv
// Fetch-stage sequencer: owns the PC, drives the combinational fetch bus and
// registers {pc, instr, exception} into the decode-facing output stage.
module if_ctrl
  import if_ctrl_pkg::*;
#(
  parameter int unsigned         PC_WIDTH    = PC_WIDTH_DEF,
  parameter int unsigned         INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(RESET_PC_DEF)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                redirect_valid_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  input  logic                trap_valid_i,
  input  logic [PC_WIDTH-1:0] trap_pc_i,
  if_ctrl_if.master           bus
);

  localparam int unsigned ENTRY_W = PC_WIDTH + INSTR_WIDTH + 2;

  logic [PC_WIDTH-1:0] pc;
  ifc_state_e          state;
  exc_e                code;
  logic                flush;
  logic                fetch_valid;
  logic                out_in_ready;
  logic                accept;
  logic [ENTRY_W-1:0]  entry_in;
  logic [ENTRY_W-1:0]  entry_out;

  assign bus.fetch_pc_o = pc;
  assign code           = exc_code(bus.fetch_misalign_i, bus.fetch_bus_err_i);
  assign flush          = trap_valid_i || redirect_valid_i;
  assign fetch_valid    = (state == IFC_RUN);
  assign accept         = fetch_valid && out_in_ready;
  assign entry_in       = {pc, bus.fetch_instr_i, code};

  // A faulting fetch is captured once, then PC freezes until a redirect/trap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      state <= IFC_RUN;
    end else if (trap_valid_i) begin
      pc    <= trap_pc_i;
      state <= IFC_RUN;
    end else if (redirect_valid_i) begin
      pc    <= redirect_pc_i;
      state <= IFC_RUN;
    end else if (accept) begin
      if (code == EXC_NONE) pc    <= pc + PC_WIDTH'(4);
      else                  state <= IFC_HALT;
    end
  end

  // Flush has priority inside the output stage, so a redirect/trap drops the
  // current fetch and any held entry regardless of id_ready_i.
  if_out_reg #(
    .WIDTH (ENTRY_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (fetch_valid),
    .in_ready  (out_in_ready),
    .in_data   (entry_in),
    .out_valid (bus.id_valid_o),
    .out_ready (bus.id_ready_i),
    .out_data  (entry_out)
  );

  assign {bus.id_pc_o, bus.id_instr_o, bus.id_exc_o} = entry_out;

endmodule

// File: tb/tb_if_ctrl.sv
// Bench for if_ctrl: directed scenarios plus randomized redirects, traps,
// bus errors and decode stalls, checked against a behavioural fetch model.
module tb_if_ctrl;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        trap_valid_i;
  logic [31:0] trap_pc_i;
  logic        berr_drv;
  logic        w_rv;
  logic [31:0] w_rpc;

  int unsigned n_cmp;
  int unsigned n_bad;

  // Behavioural model state
  logic [31:0] m_pc;
  logic        m_halt;
  logic        m_valid;
  logic [31:0] m_epc;
  logic [31:0] m_einstr;
  logic [1:0]  m_eexc;

  if_ctrl_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();
  if_ctrl_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bw ();

  if_ctrl #(
    .PC_WIDTH    (32),
    .INSTR_WIDTH (32),
    .RESET_PC    (32'h0000_0000)
  ) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .trap_valid_i     (trap_valid_i),
    .trap_pc_i        (trap_pc_i),
    .bus              (bus.master)
  );

  if_ctrl #(
    .PC_WIDTH    (32),
    .INSTR_WIDTH (32),
    .RESET_PC    (32'hFFFF_FFFC)
  ) u_dut_wrap (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_valid_i (w_rv),
    .redirect_pc_i    (w_rpc),
    .trap_valid_i     (1'b0),
    .trap_pc_i        (32'h0),
    .bus              (bw.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Instruction memory: combinational response to whatever PC the DUT presents.
  always_comb begin
    bus.fetch_instr_i    = mem_word(bus.fetch_pc_o);
    bus.fetch_misalign_i = (bus.fetch_pc_o[1:0] != 2'b00);
    bus.fetch_bus_err_i  = berr_drv;
  end

  always_comb begin
    bw.fetch_instr_i    = mem_word(bw.fetch_pc_o);
    bw.fetch_misalign_i = (bw.fetch_pc_o[1:0] != 2'b00);
    bw.fetch_bus_err_i  = 1'b0;
  end

  assign bw.id_ready_i = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    check("fetch_pc", 64'(bus.fetch_pc_o), 64'(m_pc));
    check("id_valid", 64'(bus.id_valid_o), 64'(m_valid));
    check("id_pc",    64'(bus.id_pc_o),    64'(m_epc));
    check("id_instr", 64'(bus.id_instr_o), 64'(m_einstr));
    check("id_exc",   64'(bus.id_exc_o),   64'(m_eexc));
  endtask

  // One clock: apply inputs, advance the model by the fetch rules, then compare.
  task automatic step(input logic rst, input logic rv, input logic [31:0] rpc,
                      input logic tv, input logic [31:0] tpc,
                      input logic rdy, input logic berr);
    logic [1:0] cur_exc;
    rst_n            = rst;
    redirect_valid_i = rv;
    redirect_pc_i    = rpc;
    trap_valid_i     = tv;
    trap_pc_i        = tpc;
    bus.id_ready_i   = rdy;
    berr_drv         = berr;

    cur_exc = (m_pc[1:0] != 2'b00) ? 2'b01 : (berr ? 2'b10 : 2'b00);
    if (!rst) begin
      m_pc = 32'h0; m_halt = 1'b0; m_valid = 1'b0;
      m_epc = 32'h0; m_einstr = 32'h0; m_eexc = 2'b00;
    end else if (tv || rv) begin
      m_pc    = tv ? tpc : rpc;
      m_halt  = 1'b0;
      m_valid = 1'b0;
    end else if (!m_halt && (!m_valid || rdy)) begin
      m_valid  = 1'b1;
      m_epc    = m_pc;
      m_einstr = mem_word(m_pc);
      m_eexc   = cur_exc;
      if (cur_exc == 2'b00) m_pc = m_pc + 32'd4;
      else                  m_halt = 1'b1;
    end else if (m_halt && m_valid && rdy) begin
      m_valid = 1'b0;
    end

    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic run(input logic rdy, input logic berr);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, rdy, berr);
  endtask

  initial begin
    logic [31:0] tgt;
    n_cmp = 0;
    n_bad = 0;
    w_rv  = 1'b0;
    w_rpc = 32'h0;
    m_pc  = 32'h0;
    m_halt = 1'b0; m_valid = 1'b0;
    m_epc = 32'h0; m_einstr = 32'h0; m_eexc = 2'b00;

    // Reset
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("rst_valid", 64'(bus.id_valid_o), 64'd0);
    check("rst_fetch_pc", 64'(bus.fetch_pc_o), 64'h0);
    check("w_rst_pc", 64'(bw.fetch_pc_o), 64'hFFFF_FFFC);

    // Streaming, plus PC wrap on the RESET_PC=0xFFFF_FFFC instance
    run(1'b1, 1'b0);
    check("seq_pc0", 64'(bus.id_pc_o), 64'h0);
    check("w_first_pc", 64'(bw.id_pc_o), 64'hFFFF_FFFC);
    check("w_first_valid", 64'(bw.id_valid_o), 64'd1);
    run(1'b1, 1'b0);
    check("seq_pc4", 64'(bus.id_pc_o), 64'h4);
    check("w_wrap_pc", 64'(bw.id_pc_o), 64'h0);
    run(1'b1, 1'b0);
    check("seq_pc8", 64'(bus.id_pc_o), 64'h8);
    check("seq_exc", 64'(bus.id_exc_o), 64'd0);

    // Decode stall
    for (int i = 0; i < 3; i++) begin
      run(1'b0, 1'b0);
      check("stall_pc", 64'(bus.id_pc_o), 64'h8);
      check("stall_instr", 64'(bus.id_instr_o), 64'(mem_word(32'h8)));
      check("stall_fetch", 64'(bus.fetch_pc_o), 64'hC);
    end
    run(1'b1, 1'b0);
    check("release_pc", 64'(bus.id_pc_o), 64'hC);

    // Trap beats redirect in the same cycle
    step(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b0);
    check("trap_bubble", 64'(bus.id_valid_o), 64'd0);
    check("trap_fetch", 64'(bus.fetch_pc_o), 64'h200);
    run(1'b1, 1'b0);
    check("trap_pc", 64'(bus.id_pc_o), 64'h200);
    check("trap_valid", 64'(bus.id_valid_o), 64'd1);

    // Misaligned redirect halts fetch
    step(1'b1, 1'b1, 32'h102, 1'b0, 32'h0, 1'b1, 1'b0);
    run(1'b1, 1'b0);
    check("mis_pc", 64'(bus.id_pc_o), 64'h102);
    check("mis_exc", 64'(bus.id_exc_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      run(1'b1, 1'b0);
      check("halt_fetch", 64'(bus.fetch_pc_o), 64'h102);
      check("halt_valid", 64'(bus.id_valid_o), 64'd0);
    end
    step(1'b1, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 1'b0);
    run(1'b1, 1'b0);
    check("resume_pc", 64'(bus.id_pc_o), 64'h300);
    check("resume_exc", 64'(bus.id_exc_o), 64'd0);

    // Bus error, then trap while decode is stalled
    step(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
    run(1'b1, 1'b1);
    check("berr_pc", 64'(bus.id_pc_o), 64'h40);
    check("berr_exc", 64'(bus.id_exc_o), 64'd2);
    run(1'b0, 1'b0);
    check("berr_hold", 64'(bus.id_valid_o), 64'd1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b0);
    check("flush_stalled", 64'(bus.id_valid_o), 64'd0);
    run(1'b1, 1'b0);
    check("trap80_pc", 64'(bus.id_pc_o), 64'h80);

    // Reset wins over a same-cycle redirect
    w_rv  = 1'b1;
    w_rpc = 32'h500;
    step(1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 1'b0);
    check("rst_redir_pc", 64'(bus.fetch_pc_o), 64'h0);
    check("w_rst_redir_pc", 64'(bw.fetch_pc_o), 64'hFFFF_FFFC);
    check("w_rst_redir_valid", 64'(bw.id_valid_o), 64'd0);
    w_rv = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tgt = $urandom;
      if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
      step(($urandom_range(99) != 0),
           ($urandom_range(9) == 0), tgt,
           ($urandom_range(19) == 0), {tgt[15:0], tgt[31:16]} & 32'hFFFF_FFFC,
           ($urandom_range(9) < 7),
           ($urandom_range(19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_ctrl.md
Name: if_ctrl

Overview:
- Fetch-stage sequencer. Owns the PC register and drives the combinational instruction-fetch bus each cycle.
- Registers the returned {pc, instr, exception} into a single-entry valid/ready output stage feeding decode.
- Handles branch redirects and trap vectoring.
- Stops fetching after a faulting fetch until a redirect or trap arrives.

Parameters:
- PC_WIDTH, 32, width of PC and redirect targets.
- INSTR_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- redirect_valid_i  in  1  branch/jump redirect from execute
- redirect_pc_i  in  PC_WIDTH  redirect target
- trap_valid_i  in  1  trap/exception vector request
- trap_pc_i  in  PC_WIDTH  trap vector target
- fetch_pc_o  out  PC_WIDTH  address to instruction bus (combinational from PC register)
- fetch_instr_i  in  INSTR_WIDTH  instruction returned same cycle
- fetch_misalign_i  in  1  bus flags PC[1:0]!=0
- fetch_bus_err_i  in  1  bus error
- id_valid_o  out  1  output entry valid
- id_ready_i  in  1  decode accepts entry
- id_pc_o  out  PC_WIDTH  PC of output entry
- id_instr_o  out  INSTR_WIDTH  instruction of output entry
- id_exc_o  out  2  00 none, 01 misalign, 10 bus error

Behaviour:
- Reset (rst_n==0 at a rising edge) overrides all other inputs, including a same-cycle redirect. Resulting values:
  - pc = RESET_PC
  - state = RUN
  - id_valid_o = 0
  - id_pc_o = 0, id_instr_o = 0, id_exc_o = 00
- fetch_pc_o = pc at all times. The bus is combinational, so instr and exception flags are valid in the same cycle.
- Exception encoding of the current fetch: misalign → 01; else bus_err → 10; else 00. Misalign wins when both flags are set.
- Definition: accept = (state==RUN) && (!id_valid_o || id_ready_i).
- States:
  - RUN: normal fetch.
  - HALT: a faulting fetch has been captured; fetch is suspended.
- Priority per edge: reset > trap > redirect > normal.
- Trap or redirect (any state):
  - pc <= trap_pc_i if trap_valid_i, else redirect_pc_i.
  - id_valid_o <= 0. This flushes the output entry even if id_ready_i==0.
  - The current fetch is discarded.
  - state <= RUN.
  - The target's entry is presented valid one edge later: exactly one bubble cycle.
- Normal, state RUN, accept:
  - id_pc_o <= pc; id_instr_o <= fetch_instr_i; id_exc_o <= code; id_valid_o <= 1.
  - If code==00: pc <= pc+4, modulo 2^PC_WIDTH (0xFFFF_FFFC wraps to 0).
  - Otherwise: pc holds and state <= HALT.
- Normal, state RUN, !accept (decode stalled): pc and output entry hold. The output entry must stay stable while valid && !ready.
- Normal, state HALT:
  - pc holds; no new capture.
  - If id_valid_o && id_ready_i: id_valid_o <= 0.
  - id_pc_o, id_instr_o and id_exc_o hold their last values.
- Throughput: one instruction per cycle when id_ready_i is held at 1.
- Redirect targets are loaded unchecked. Misalignment is detected on the following fetch via fetch_misalign_i.

Decomposition:
- Shared defines file holds: PC_WIDTH, INSTR_WIDTH, RESET_PC, exception codes (EXC_NONE=2'b00, EXC_MISALIGN=2'b01, EXC_BUS_ERR=2'b10), state encodings (IFC_RUN, IFC_HALT).
- One natural sub-module: if_out_reg, a single-entry valid/ready pipeline register with a synchronous flush input.
- The PC/FSM logic stays in if_ctrl.

Test Plan:
- Reset then id_ready_i=1, clean fetches: id_pc_o sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles, id_exc_o=00.
- id_ready_i=0 for 3 cycles while id_pc_o=0x8: id_pc_o and id_instr_o stay stable and fetch_pc_o holds 0xC. After release, the next entry is 0xC.
- redirect_valid_i with redirect_pc_i=0x100 and trap_valid_i with trap_pc_i=0x200 asserted the same cycle: next edge id_valid_o=0 and fetch_pc_o=0x200. The following edge gives id_pc_o=0x200, valid.
- Redirect to 0x102: the entry for 0x102 has id_exc_o=01 and state goes to HALT. fetch_pc_o stays 0x102 for 5 cycles with no new valid entry after decode accepts. A redirect to 0x300 resumes fetch.
- fetch_bus_err_i=1 at pc 0x40: id_exc_o=10, then HALT. A trap to 0x80 gives a one-cycle bubble, then id_pc_o=0x80.
- RESET_PC=0xFFFF_FFFC: the first entry is 0xFFFF_FFFC, the next is 0x0. Then rst_n=0 in the same cycle as a redirect: pc returns to RESET_PC and id_valid_o=0.
